// File: rtl/time_set_controller.sv
// Button-driven hour/minute setter for the FND clock: debounce, edit FSM, load strobe, blink mask.
// Optional AUTO_REPEAT_EN adds hold-to-repeat stepping on the up/down buttons.
module time_set_controller #(
  parameter int DEBOUNCE_CYCLES = 20,
  parameter int BLINK_HALF      = 250,
  parameter int TIMEOUT         = 10000
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_btn_mode,
  input  logic       i_btn_up,
  input  logic       i_btn_down,
  input  logic [5:0] i_hour,
  input  logic [5:0] i_min,
  output logic [5:0] o_set_hour,
  output logic [5:0] o_set_min,
  output logic       o_load,
  output logic       o_setting,
  output logic [3:0] o_blank
);

  localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int BL_W = $clog2(BLINK_HALF + 1);
  localparam int TO_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, SET_HOUR, SET_MIN, COMMIT} state_t;

  // Bit order for all per-button vectors: [2]=mode, [1]=up, [0]=down
  logic [2:0]      raw;
  logic [2:0]      sync1;
  logic [2:0]      sync2;
  logic [2:0]      level;
  logic [2:0]      level_q;
  logic [2:0]      press;
  logic [DB_W-1:0] db_cnt [3];

  state_t          state;
  logic            setting;
  logic            load;
  logic [5:0]      edit_hour;
  logic [5:0]      edit_min;
  logic [TO_W-1:0] to_cnt;
  logic [BL_W-1:0] blink_cnt;
  logic            phase;

  logic            mode_press;
  logic            step_up;
  logic            step_dn;
  logic            any_press;

  function automatic logic [5:0] step_wrap(input logic [5:0] v, input logic [5:0] top,
                                           input logic up);
    if (up) return (v >= top) ? 6'd0 : v + 6'd1;
    else    return (v == 6'd0) ? top : v - 6'd1;
  endfunction

  assign raw = {i_btn_mode, i_btn_up, i_btn_down};

  // Synchronize, then accept a new level only after DEBOUNCE_CYCLES identical differing samples
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      sync1   <= '0;
      sync2   <= '0;
      level   <= '0;
      level_q <= '0;
      press   <= '0;
      for (int i = 0; i < 3; i++) db_cnt[i] <= '0;
    end else begin
      sync1   <= raw;
      sync2   <= sync1;
      level_q <= level;
      press   <= level & ~level_q;
      for (int i = 0; i < 3; i++) begin
        if (sync2[i] == level[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DB_W'(DEBOUNCE_CYCLES - 1)) begin
          level[i]  <= sync2[i];
          db_cnt[i] <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + 1'b1;
        end
      end
    end
  end

`ifdef AUTO_REPEAT_EN
  localparam int REPEAT_DELAY  = 500;
  localparam int REPEAT_PERIOD = 100;
  localparam int RP_W          = $clog2(REPEAT_DELAY + 1);

  logic [1:0]      armed;
  logic [1:0]      rep;
  logic [RP_W-1:0] rep_cnt [2];

  // A repeat is armed only by a press taken in a set state; the counter starts at 1 so the
  // first repeat lands exactly REPEAT_DELAY cycles after the press pulse.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      armed <= '0;
      rep   <= '0;
      for (int i = 0; i < 2; i++) rep_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        rep[i] <= 1'b0;
        if (press[i] && setting) begin
          armed[i]   <= 1'b1;
          rep_cnt[i] <= RP_W'(1);
        end else if (armed[i] && level[i] && setting) begin
          if (rep_cnt[i] == RP_W'(REPEAT_DELAY - 1)) begin
            rep[i]     <= 1'b1;
            rep_cnt[i] <= RP_W'(REPEAT_DELAY - REPEAT_PERIOD);
          end else begin
            rep_cnt[i] <= rep_cnt[i] + 1'b1;
          end
        end else begin
          armed[i]   <= 1'b0;
          rep_cnt[i] <= '0;
        end
      end
    end
  end

  assign step_up = press[1] | rep[1];
  assign step_dn = press[0] | rep[0];
`else
  assign step_up = press[1];
  assign step_dn = press[0];
`endif

  assign mode_press = press[2];
  assign any_press  = mode_press | step_up | step_dn;

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state     <= IDLE;
      setting   <= 1'b0;
      load      <= 1'b0;
      edit_hour <= '0;
      edit_min  <= '0;
      to_cnt    <= '0;
      blink_cnt <= '0;
      phase     <= 1'b0;
    end else begin
      load <= 1'b0;
      case (state)
        IDLE: begin
          to_cnt    <= '0;
          blink_cnt <= '0;
          phase     <= 1'b0;
          if (mode_press) begin
            state     <= SET_HOUR;
            setting   <= 1'b1;
            edit_hour <= i_hour;
            edit_min  <= i_min;
          end
        end
        SET_HOUR, SET_MIN: begin
          if (mode_press) begin
            to_cnt    <= '0;
            blink_cnt <= '0;
            phase     <= 1'b0;
            if (state == SET_HOUR) begin
              state <= SET_MIN;
            end else begin
              state   <= COMMIT;
              setting <= 1'b0;
              load    <= 1'b1;
            end
          end else if (!any_press && to_cnt == TO_W'(TIMEOUT - 1)) begin
            state     <= IDLE;
            setting   <= 1'b0;
            to_cnt    <= '0;
            blink_cnt <= '0;
            phase     <= 1'b0;
          end else begin
            to_cnt <= any_press ? '0 : to_cnt + 1'b1;
            // Up and down together cancel: no step, blink keeps running
            if (step_up ^ step_dn) begin
              blink_cnt <= '0;
              phase     <= 1'b0;
              if (state == SET_HOUR) edit_hour <= step_wrap(edit_hour, 6'd23, step_up);
              else                   edit_min  <= step_wrap(edit_min, 6'd59, step_up);
            end else if (blink_cnt == BL_W'(BLINK_HALF - 1)) begin
              blink_cnt <= '0;
              phase     <= ~phase;
            end else begin
              blink_cnt <= blink_cnt + 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign o_set_hour = edit_hour;
  assign o_set_min  = edit_min;
  assign o_load     = load;
  assign o_setting  = setting;
  assign o_blank    = (state == SET_HOUR) ? {phase, phase, 2'b00} :
                      (state == SET_MIN)  ? {2'b00, phase, phase} : 4'b0000;

endmodule

// File: tb/tb_time_set_controller.sv
// Directed bench for time_set_controller: vector table for editing plus hand sequences for
// latency, blink, commit, timeout, async reset and (when AUTO_REPEAT_EN is defined) auto-repeat.
module tb_time_set_controller;

  localparam int TIMEOUT = 10000;

  logic       clk;
  logic       rst_n;
  logic       btn_mode, btn_up, btn_down;
  logic [5:0] hour_in, min_in;
  logic [5:0] set_hour, set_min;
  logic       load, setting;
  logic [3:0] blank;

  int pass_cnt = 0;
  int total    = 0;
  int load_cnt = 0;
  int ld_hour  = 0;
  int ld_min   = 0;
  int lc;

  typedef struct {
    logic [2:0] btn;
    int         hold;
    logic [5:0] exp_hour;
    logic [5:0] exp_min;
    logic       exp_setting;
  } vec_t;

  vec_t tbl [19];

  time_set_controller dut (
    .i_clk(clk), .i_reset(rst_n),
    .i_btn_mode(btn_mode), .i_btn_up(btn_up), .i_btn_down(btn_down),
    .i_hour(hour_in), .i_min(min_in),
    .o_set_hour(set_hour), .o_set_min(set_min),
    .o_load(load), .o_setting(setting), .o_blank(blank)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (load) begin
      load_cnt = load_cnt + 1;
      ld_hour  = int'(set_hour);
      ld_min   = int'(set_min);
    end
  end

  task automatic check(input string name, input int act, input int exp);
    total = total + 1;
    if (act === exp) pass_cnt = pass_cnt + 1;
    else $display("FAIL %s: actual %0d, expected %0d", name, act, exp);
  endtask

  // btn = {mode, up, down}; returns #1 after the 70th edge following the press start
  task automatic press(input logic [2:0] btn, input int hold);
    @(posedge clk); #1 {btn_mode, btn_up, btn_down} = btn;
    repeat (hold) @(posedge clk);
    #1 {btn_mode, btn_up, btn_down} = 3'b000;
    repeat (40) @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 11; i++)
      tbl[i] = '{3'b010, 30, 6'((14 + i) % 24), 6'd45, 1'b1};
    tbl[11] = '{3'b011, 30, 6'd0,  6'd45, 1'b1};
    tbl[12] = '{3'b001, 30, 6'd23, 6'd45, 1'b1};
    tbl[13] = '{3'b010, 30, 6'd0,  6'd45, 1'b1};
    tbl[14] = '{3'b010, 10, 6'd0,  6'd45, 1'b1};
    tbl[15] = '{3'b100, 30, 6'd0,  6'd45, 1'b1};
    tbl[16] = '{3'b001, 30, 6'd0,  6'd44, 1'b1};
    tbl[17] = '{3'b010, 30, 6'd0,  6'd45, 1'b1};
    tbl[18] = '{3'b100, 30, 6'd0,  6'd45, 1'b0};

    rst_n = 1'b0;
    {btn_mode, btn_up, btn_down} = 3'b000;
    hour_in = 6'd13;
    min_in  = 6'd45;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset load", int'(load), 0);
    check("reset setting", int'(setting), 0);
    check("reset blank", int'(blank), 0);
    check("reset set_hour", int'(set_hour), 0);
    check("reset set_min", int'(set_min), 0);
    rst_n = 1'b1;

    // Mode press latency: raw edge at edge 0, pulse after edge 23, state change at edge 24
    repeat (2) @(posedge clk);
    #1 btn_mode = 1'b1;
    repeat (23) @(posedge clk);
    @(negedge clk);
    check("latency before pulse", int'(setting), 0);
    @(negedge clk);
    check("latency enter setting", int'(setting), 1);
    check("capture hour", int'(set_hour), 13);
    check("capture min", int'(set_min), 45);
    check("entry blank visible", int'(blank), 0);
    repeat (6) @(posedge clk);
    #1 btn_mode = 1'b0;
    repeat (243) @(posedge clk);
    @(negedge clk);
    check("blink before toggle", int'(blank), 0);
    @(negedge clk);
    check("blink hour toggle", int'(blank), 4'b1100);

    for (int i = 0; i < 19; i++) begin
      press(tbl[i].btn, tbl[i].hold);
      check($sformatf("vec%0d hour", i), int'(set_hour), int'(tbl[i].exp_hour));
      check($sformatf("vec%0d min", i), int'(set_min), int'(tbl[i].exp_min));
      check($sformatf("vec%0d setting", i), int'(setting), int'(tbl[i].exp_setting));
    end
    check("table load count", load_cnt, 1);
    check("table load hour", ld_hour, 0);
    check("table load min", ld_min, 45);
    check("table idle blank", int'(blank), 0);

    // Minute wrap both ways, blink in SET_MIN, then timeout abort
    hour_in = 6'd5;
    min_in  = 6'd0;
    lc = load_cnt;
    press(3'b100, 30);
    check("capture2 hour", int'(set_hour), 5);
    check("capture2 min", int'(set_min), 0);
    press(3'b100, 30);
    repeat (210) @(posedge clk);
    #1;
    check("blink min toggle", int'(blank), 4'b0011);
    press(3'b001, 30);
    check("min wrap down", int'(set_min), 59);
    check("blink reset on step", int'(blank), 0);
    press(3'b010, 30);
    check("min wrap up", int'(set_min), 0);
    repeat (TIMEOUT - 100) @(posedge clk);
    #1;
    check("before timeout", int'(setting), 1);
    repeat (100) @(posedge clk);
    #1;
    check("after timeout", int'(setting), 0);
    check("timeout blank", int'(blank), 0);
    check("timeout no load", load_cnt, lc);

    // Full edit: 13:45 -> 14:44 with a single load
    hour_in = 6'd13;
    min_in  = 6'd45;
    lc = load_cnt;
    press(3'b100, 30);
    press(3'b010, 30);
    press(3'b100, 30);
    press(3'b001, 30);
    press(3'b100, 30);
    check("commit load once", load_cnt, lc + 1);
    check("commit hour", ld_hour, 14);
    check("commit min", ld_min, 44);
    check("commit idle", int'(setting), 0);
    check("commit blank", int'(blank), 0);

    // Asynchronous reset in SET_HOUR
    lc = load_cnt;
    press(3'b100, 30);
    check("pre-reset setting", int'(setting), 1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("async rst setting", int'(setting), 0);
    check("async rst hour", int'(set_hour), 0);
    check("async rst min", int'(set_min), 0);
    check("async rst load", int'(load), 0);
    check("async rst blank", int'(blank), 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (50) @(posedge clk);
    #1;
    check("post-reset idle", int'(setting), 0);
    check("post-reset no load", load_cnt, lc);

    // Long hold of up in SET_MIN from 0
    hour_in = 6'd0;
    min_in  = 6'd0;
    press(3'b100, 30);
    press(3'b100, 30);
    press(3'b010, 1050);
`ifdef AUTO_REPEAT_EN
    check("auto repeat min", int'(set_min), 7);
`else
    check("long hold single step", int'(set_min), 1);
`endif
    check("long hold hour", int'(set_hour), 0);
    check("long hold setting", int'(setting), 1);

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
